video_dram_arb: RTL and testbench
=================================

Name: video_dram_arb

Overview:
- Arbiter that schedules DRAM cycles for the video subsystem and the Z80 CPU.
- Sits directly upstream of the video top block: it consumes the requests that block produces (video_addr/video_bw/video_go, ts_addr/ts_req/ts_z80_lp, tm_addr/tm_req) and returns the strobes that block consumes (video_pre_next, video_next, next_video, video_strobe, ts_pre_next, ts_next, tm_next).
- One DRAM cycle = 4 clk phases, c0..c3 (one-hot). Each cycle is owned by exactly one client or left idle.

Parameters:
- CPU_STARVE, 4, number of consecutive free slots a pending CPU request may lose before it is forced to win.

Ports:
- clk  in  1  system clock
- res  in  1  synchronous active-high reset
- c0, c1, c2, c3  in  1 each  DRAM phase strobes, one-hot, one per clk
- video_addr  in  21  video word address
- video_bw  in  5  [2:0]=video slots per window minus 1; [4:3]=window length select (00=8, 01=16, 1x=32 cycles)
- video_go  in  1  video fetch window active
- ts_addr  in  21  TS render address
- ts_req  in  1  TS render request
- ts_z80_lp  in  1  1 = CPU below TS/TM in priority
- tm_addr  in  21  tile-map address
- tm_req  in  1  tile-map request
- cpu_addr  in  21  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_rnw  in  1  1 = read
- cpu_req  in  1  CPU request, held until cpu_next
- video_pre_next, ts_pre_next  out  1  next cycle granted to this client
- video_next, ts_next, tm_next, cpu_next  out  1  address accepted
- next_video  out  1  current cycle owned by video
- video_strobe, cpu_strobe  out  1  read data valid on dram_rdata
- dram_addr  out  21  DRAM address
- dram_wdata  out  16  DRAM write data
- dram_req  out  1  cycle active
- dram_rnw  out  1  1 = read

Behaviour:
- Reset: all outputs 0, dram_rnw=1, owner=IDLE, slot counter=0, starve counter=0. Reset mid-cycle aborts the cycle; no next or strobe pulses follow.
- Owner states: IDLE, VID, TM, TS, CPU. The owner is decided on a clk with c3=1 and registered; it holds for the following c0..c3.
- Slot counter: 5 bits; advances on every c3; wraps at the window length W; forced to 0 on the c3 clk when video_go=0.
- Video slot: video_go=1 and slot < video_bw[2:0]+1. If video_bw[2:0]+1 >= W, every slot is a video slot.
- Decision on the c3 clk:
  - In a video slot, VID wins unconditionally.
  - Otherwise the winner is the highest-priority active request:
    - ts_z80_lp=0: CPU > TM > TS.
    - ts_z80_lp=1: TM > TS > CPU.
  - Starvation override: if the starve counter has reached CPU_STARVE and cpu_req=1, CPU wins in any non-video slot.
  - No request: IDLE.
- Starve counter: increments on each non-video c3 decision where cpu_req=1 and CPU loses. Clears when CPU wins or cpu_req=0. Saturates at CPU_STARVE.
- video_pre_next / ts_pre_next: combinational, high on the deciding c3 clk only.
- Registered on the clk after the deciding c3 (i.e. with c0):
  - owner's *_next: 1-clk pulse.
  - dram_req=1 and dram_addr = owner's address, held through c3; dram_req=0 on the next decision if IDLE.
  - dram_rnw=0 with cpu_wdata latched only for CPU with cpu_rnw=0; all other owners read.
  - next_video=1 for the whole VID cycle (c0..c3).
- video_strobe / cpu_strobe: 1-clk pulse at c3 of an owned read cycle. No cpu_strobe on CPU writes.
- Decision and data strobe coincide on c3: the new owner's pre_next and the old owner's strobe may both be high on the same clk.
- Request dropped after decision: the cycle still runs. Clients ignore unsolicited next pulses.
- Phase fault: if no c* is high, state holds.
- Address inputs are sampled only at grant. Widths are fixed; no arithmetic beyond the counters.

Test Plan:
- Reset held 3 clk, then released with no requests → all strobes 0, dram_req=0, owner IDLE across 4 DRAM cycles.
- video_go=1, video_bw=5'b00_011 (4 of 8), tm_req=1 permanently → per 8-cycle window: cycles 0-3 VID (video_next at c0, video_strobe at c3), cycles 4-7 TM; pattern repeats.
- video_go falls mid-window → slot counter clears at next c3; subsequent slots go to TM/TS/CPU; when video_go rises, VID owns cycle 0 of the fresh window.
- ts_z80_lp=1, ts_req and cpu_req held, no video → TS wins 4 cycles; 5th decision goes to CPU via starve override; cpu_next pulses once; starve counter clears.
- CPU write: cpu_req=1, cpu_rnw=0, cpu_wdata=16'hA55A, cpu_addr=21'h1F000 → dram_rnw=0, dram_wdata=A55A, dram_addr=1F000 during c0..c3; cpu_next pulses; no cpu_strobe.
- res asserted at c1 of a VID cycle → next clk all outputs 0; no video_strobe for that cycle.

Source files
------------

// File: rtl/video_dram_arb.sv
// DRAM cycle arbiter for the video subsystem (video fetch, tile map, TS render) and the Z80 CPU.
// Each 4-phase DRAM cycle is awarded on c3 and runs over the following c0..c3.
module video_dram_arb #(
  parameter int CPU_STARVE = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic        c0,
  input  logic        c1,
  input  logic        c2,
  input  logic        c3,
  input  logic [20:0] video_addr,
  input  logic [4:0]  video_bw,
  input  logic        video_go,
  input  logic [20:0] ts_addr,
  input  logic        ts_req,
  input  logic        ts_z80_lp,
  input  logic [20:0] tm_addr,
  input  logic        tm_req,
  input  logic [20:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_rnw,
  input  logic        cpu_req,
  output logic        video_pre_next,
  output logic        ts_pre_next,
  output logic        video_next,
  output logic        ts_next,
  output logic        tm_next,
  output logic        cpu_next,
  output logic        next_video,
  output logic        video_strobe,
  output logic        cpu_strobe,
  output logic [20:0] dram_addr,
  output logic [15:0] dram_wdata,
  output logic        dram_req,
  output logic        dram_rnw
);

  localparam int SW = (CPU_STARVE < 1) ? 1 : $clog2(CPU_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE);

  typedef enum logic [2:0] {
    OWN_IDLE = 3'd0,
    OWN_VID  = 3'd1,
    OWN_TM   = 3'd2,
    OWN_TS   = 3'd3,
    OWN_CPU  = 3'd4
  } owner_t;

  // A phase word that is not exactly one-hot is treated as a fault: nothing advances.
  function automatic logic onehot4(input logic [3:0] v);
    return (v == 4'b0001) || (v == 4'b0010) || (v == 4'b0100) || (v == 4'b1000);
  endfunction

  owner_t      owner_r;
  owner_t      winner_s;
  logic [4:0]  slot_r;
  logic [4:0]  slot_nxt_s;
  logic [4:0]  win_last_s;
  logic [4:0]  vid_slots_s;
  logic [SW-1:0] starve_r;
  logic [SW-1:0] starve_nxt_s;
  logic        phase_ok_s;
  logic        dec_s;
  logic        str_s;
  logic        video_slot_s;
  logic        starved_s;
  logic        cpu_wr_s;
  logic [20:0] grant_addr_s;

  logic        video_next_r;
  logic        ts_next_r;
  logic        tm_next_r;
  logic        cpu_next_r;
  logic        next_video_r;
  logic        video_strobe_r;
  logic        cpu_strobe_r;
  logic [20:0] dram_addr_r;
  logic [15:0] dram_wdata_r;
  logic        dram_req_r;
  logic        dram_rnw_r;

  // Window position, winner selection and starvation bookkeeping for the pending decision.
  always_comb begin
    phase_ok_s = onehot4({c3, c2, c1, c0});
    dec_s      = c3 && phase_ok_s;
    str_s      = c2 && phase_ok_s;

    case (video_bw[4:3])
      2'b00:   win_last_s = 5'd7;
      2'b01:   win_last_s = 5'd15;
      default: win_last_s = 5'd31;
    endcase

    vid_slots_s  = {2'b00, video_bw[2:0]} + 5'd1;
    video_slot_s = video_go && (slot_r < vid_slots_s);
    starved_s    = cpu_req && (starve_r >= STARVE_MAX);

    winner_s = OWN_IDLE;
    if (video_slot_s) begin
      winner_s = OWN_VID;
    end else if (starved_s) begin
      winner_s = OWN_CPU;
    end else if (!ts_z80_lp) begin
      if (cpu_req)     winner_s = OWN_CPU;
      else if (tm_req) winner_s = OWN_TM;
      else if (ts_req) winner_s = OWN_TS;
      else             winner_s = OWN_IDLE;
    end else begin
      if (tm_req)       winner_s = OWN_TM;
      else if (ts_req)  winner_s = OWN_TS;
      else if (cpu_req) winner_s = OWN_CPU;
      else              winner_s = OWN_IDLE;
    end

    // ">=" also recovers cleanly when the window is shortened mid-window.
    if (!video_go || (slot_r >= win_last_s)) begin
      slot_nxt_s = 5'd0;
    end else begin
      slot_nxt_s = slot_r + 5'd1;
    end

    if (!cpu_req || (winner_s == OWN_CPU)) begin
      starve_nxt_s = {SW{1'b0}};
    end else if (!video_slot_s && (starve_r < STARVE_MAX)) begin
      starve_nxt_s = starve_r + SW'(1'b1);
    end else begin
      starve_nxt_s = starve_r;
    end

    case (winner_s)
      OWN_VID: grant_addr_s = video_addr;
      OWN_TM:  grant_addr_s = tm_addr;
      OWN_TS:  grant_addr_s = ts_addr;
      OWN_CPU: grant_addr_s = cpu_addr;
      default: grant_addr_s = 21'd0;
    endcase

    cpu_wr_s = (winner_s == OWN_CPU) && !cpu_rnw;
  end

  // Owner, counters and DRAM-side registers; decisions land on c3, read strobes on c3 via c2.
  always_ff @(posedge clk) begin
    if (res) begin
      owner_r        <= OWN_IDLE;
      slot_r         <= 5'd0;
      starve_r       <= {SW{1'b0}};
      video_next_r   <= 1'b0;
      ts_next_r      <= 1'b0;
      tm_next_r      <= 1'b0;
      cpu_next_r     <= 1'b0;
      next_video_r   <= 1'b0;
      video_strobe_r <= 1'b0;
      cpu_strobe_r   <= 1'b0;
      dram_addr_r    <= 21'd0;
      dram_wdata_r   <= 16'd0;
      dram_req_r     <= 1'b0;
      dram_rnw_r     <= 1'b1;
    end else begin
      video_next_r   <= dec_s && (winner_s == OWN_VID);
      tm_next_r      <= dec_s && (winner_s == OWN_TM);
      ts_next_r      <= dec_s && (winner_s == OWN_TS);
      cpu_next_r     <= dec_s && (winner_s == OWN_CPU);
      video_strobe_r <= str_s && (owner_r == OWN_VID);
      cpu_strobe_r   <= str_s && (owner_r == OWN_CPU) && dram_rnw_r;
      if (dec_s) begin
        owner_r      <= winner_s;
        slot_r       <= slot_nxt_s;
        starve_r     <= starve_nxt_s;
        next_video_r <= (winner_s == OWN_VID);
        dram_req_r   <= (winner_s != OWN_IDLE);
        dram_rnw_r   <= !cpu_wr_s;
        if (winner_s != OWN_IDLE) begin
          dram_addr_r <= grant_addr_s;
        end
        if (cpu_wr_s) begin
          dram_wdata_r <= cpu_wdata;
        end
      end
    end
  end

  assign video_pre_next = !res && dec_s && (winner_s == OWN_VID);
  assign ts_pre_next    = !res && dec_s && (winner_s == OWN_TS);

  assign video_next   = video_next_r;
  assign ts_next      = ts_next_r;
  assign tm_next      = tm_next_r;
  assign cpu_next     = cpu_next_r;
  assign next_video   = next_video_r;
  assign video_strobe = video_strobe_r;
  assign cpu_strobe   = cpu_strobe_r;
  assign dram_addr    = dram_addr_r;
  assign dram_wdata   = dram_wdata_r;
  assign dram_req     = dram_req_r;
  assign dram_rnw     = dram_rnw_r;

endmodule

// File: tb/tb_video_dram_arb.sv
// Scoreboard bench for video_dram_arb: stimulus queues expected grants/strobes,
// a negedge monitor pops and compares whenever the arbiter pulses a next or strobe.
module tb_video_dram_arb;

  localparam logic [2:0] W_VID = 3'd1;
  localparam logic [2:0] W_TM  = 3'd2;
  localparam logic [2:0] W_TS  = 3'd3;
  localparam logic [2:0] W_CPU = 3'd4;

  typedef struct packed {
    logic [2:0]  who;
    logic [20:0] addr;
    logic        rnw;
    logic [15:0] wdata;
  } grant_t;

  logic        clk = 1'b0;
  logic        res;
  logic        c0, c1, c2, c3;
  logic [20:0] video_addr, ts_addr, tm_addr, cpu_addr;
  logic [4:0]  video_bw;
  logic        video_go, ts_req, ts_z80_lp, tm_req, cpu_rnw, cpu_req;
  logic [15:0] cpu_wdata;
  logic        video_pre_next, ts_pre_next, video_next, ts_next, tm_next, cpu_next;
  logic        next_video, video_strobe, cpu_strobe, dram_req, dram_rnw;
  logic [20:0] dram_addr;
  logic [15:0] dram_wdata;

  grant_t      gq[$];
  logic [2:0]  sq[$];
  int          checks = 0;
  int          failures = 0;
  logic [1:0]  ph;
  logic        ph_en;

  logic        own_valid;
  logic        vpn_q, tpn_q;
  logic [20:0] last_addr;
  logic        any_next;
  logic [2:0]  who_act;
  logic [2:0]  stb_act;
  grant_t      mon_g;

  always #5 clk = ~clk;

  video_dram_arb #(.CPU_STARVE(4)) dut (
    .clk(clk), .res(res), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .video_addr(video_addr), .video_bw(video_bw), .video_go(video_go),
    .ts_addr(ts_addr), .ts_req(ts_req), .ts_z80_lp(ts_z80_lp),
    .tm_addr(tm_addr), .tm_req(tm_req),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rnw(cpu_rnw), .cpu_req(cpu_req),
    .video_pre_next(video_pre_next), .ts_pre_next(ts_pre_next),
    .video_next(video_next), .ts_next(ts_next), .tm_next(tm_next), .cpu_next(cpu_next),
    .next_video(next_video), .video_strobe(video_strobe), .cpu_strobe(cpu_strobe),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_req(dram_req), .dram_rnw(dram_rnw)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ph_en) ph = ph + 2'd1;
    {c3, c2, c1, c0} = ph_en ? (4'b0001 << ph) : 4'b0000;
  endtask

  task automatic dcyc();
    repeat (4) tick();
  endtask

  task automatic push_grant(input logic [2:0] who, input logic [20:0] addr,
                            input logic rnw, input logic [15:0] wdata);
    grant_t g;
    g.who = who; g.addr = addr; g.rnw = rnw; g.wdata = wdata;
    gq.push_back(g);
  endtask

  task automatic drain(input string nm);
    dcyc();
    dcyc();
    chk({nm, "_grants_left"}, gq.size(), 0);
    chk({nm, "_strobes_left"}, sq.size(), 0);
  endtask

  // Monitor: grants and strobes are popped from the scoreboard queues as they appear.
  always @(negedge clk) begin
    if (res) begin
      own_valid = 1'b0;
    end else begin
      any_next = video_next | tm_next | ts_next | cpu_next;
      if (c0) chk("dram_req_c0", dram_req, any_next);
      if (any_next) begin
        who_act = video_next ? W_VID : tm_next ? W_TM : ts_next ? W_TS : W_CPU;
        chk("grant_phase", c0, 1);
        chk("grant_onehot", $countones({video_next, tm_next, ts_next, cpu_next}), 1);
        if (gq.size() == 0) begin
          chk("unexpected_grant", who_act, 0);
        end else begin
          mon_g = gq.pop_front();
          chk("grant_owner", who_act, mon_g.who);
          chk("grant_addr", dram_addr, mon_g.addr);
          chk("grant_rnw", dram_rnw, mon_g.rnw);
          if (!mon_g.rnw) chk("grant_wdata", dram_wdata, mon_g.wdata);
          chk("next_video", next_video, mon_g.who == W_VID);
          chk("video_pre_next", vpn_q, mon_g.who == W_VID);
          chk("ts_pre_next", tpn_q, mon_g.who == W_TS);
          last_addr = mon_g.addr;
        end
        own_valid = 1'b1;
      end else if (c0) begin
        own_valid = 1'b0;
      end
      if (c3) begin
        if (own_valid) begin
          chk("dram_req_hold", dram_req, 1);
          chk("dram_addr_hold", dram_addr, last_addr);
        end
        vpn_q = video_pre_next;
        tpn_q = ts_pre_next;
      end
      if (video_strobe || cpu_strobe) begin
        stb_act = video_strobe ? W_VID : W_CPU;
        chk("strobe_phase", c3, 1);
        chk("strobe_onehot", video_strobe & cpu_strobe, 0);
        if (sq.size() == 0) chk("unexpected_strobe", stb_act, 0);
        else chk("strobe_owner", stb_act, sq.pop_front());
      end
    end
  end

  initial begin
    res = 1'b1; ph = 2'd3; ph_en = 1'b1; {c3, c2, c1, c0} = 4'b0000;
    video_addr = 21'd0; ts_addr = 21'd0; tm_addr = 21'd0; cpu_addr = 21'd0;
    video_bw = 5'd0; video_go = 1'b0; ts_req = 1'b0; ts_z80_lp = 1'b0; tm_req = 1'b0;
    cpu_wdata = 16'd0; cpu_rnw = 1'b1; cpu_req = 1'b0;
    own_valid = 1'b0; vpn_q = 1'b0; tpn_q = 1'b0; last_addr = 21'd0;

    repeat (5) tick();
    res = 1'b0;
    chk("rst_dram_req", dram_req, 0);
    chk("rst_dram_rnw", dram_rnw, 1);
    chk("rst_dram_addr", dram_addr, 0);
    chk("rst_dram_wdata", dram_wdata, 0);
    chk("rst_next_video", next_video, 0);
    chk("rst_pulses", {video_next, ts_next, tm_next, cpu_next, video_strobe, cpu_strobe,
                       video_pre_next, ts_pre_next}, 0);

    // Idle: no requests for four DRAM cycles.
    for (int k = 0; k < 4; k++) begin
      dcyc();
      chk("idle_dram_req", dram_req, 0);
      chk("idle_next_video", next_video, 0);
    end

    // Video 4 of 8 with tile map filling the rest; addresses change each cycle.
    video_go = 1'b1; video_bw = 5'b00_011; tm_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      video_addr = 21'h10000 + 21'(k);
      tm_addr    = 21'h20000 + 21'(k);
      if ((k % 8) < 4) begin
        push_grant(W_VID, video_addr, 1'b1, 16'h0000);
        sq.push_back(W_VID);
      end else begin
        push_grant(W_TM, tm_addr, 1'b1, 16'h0000);
      end
      dcyc();
    end
    video_go = 1'b0; tm_req = 1'b0;
    drain("window");

    // video_go drops after two video slots, then restarts a fresh window.
    tm_req = 1'b1; tm_addr = 21'h2AAAA; video_addr = 21'h1BEEF;
    for (int k = 0; k < 9; k++) begin
      video_go = !((k == 2) || (k == 3));
      if ((k < 2) || ((k >= 4) && (k < 8))) begin
        push_grant(W_VID, video_addr, 1'b1, 16'h0000);
        sq.push_back(W_VID);
      end else begin
        push_grant(W_TM, tm_addr, 1'b1, 16'h0000);
      end
      dcyc();
    end
    video_go = 1'b0; tm_req = 1'b0;
    drain("go_drop");

    // CPU below TS: four TS wins, then the starvation override hands one cycle to CPU.
    ts_z80_lp = 1'b1; ts_req = 1'b1; cpu_req = 1'b1; cpu_rnw = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ts_addr  = 21'h40000 + 21'(k);
      cpu_addr = 21'h30000 + 21'(k);
      if (k == 4) begin
        push_grant(W_CPU, cpu_addr, 1'b1, 16'h0000);
        sq.push_back(W_CPU);
      end else begin
        push_grant(W_TS, ts_addr, 1'b1, 16'h0000);
      end
      dcyc();
    end
    ts_req = 1'b0; cpu_req = 1'b0; ts_z80_lp = 1'b0;
    drain("starve");

    // CPU above TS/TM: requests drop one by one as each is served.
    cpu_addr = 21'h0ABCD; tm_addr = 21'h1BCDE; ts_addr = 21'h1CDEF;
    cpu_req = 1'b1; tm_req = 1'b1; ts_req = 1'b1;
    push_grant(W_CPU, cpu_addr, 1'b1, 16'h0000);
    sq.push_back(W_CPU);
    dcyc();
    cpu_req = 1'b0;
    push_grant(W_TM, tm_addr, 1'b1, 16'h0000);
    dcyc();
    tm_req = 1'b0;
    push_grant(W_TS, ts_addr, 1'b1, 16'h0000);
    dcyc();
    ts_req = 1'b0;
    drain("prio");

    // CPU write, with a phase stall in the middle of the cycle.
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_wdata = 16'hA55A; cpu_addr = 21'h1F000;
    push_grant(W_CPU, 21'h1F000, 1'b0, 16'hA55A);
    dcyc();
    cpu_req = 1'b0; cpu_rnw = 1'b1; cpu_wdata = 16'h0000; cpu_addr = 21'h00000;
    ph_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_dram_req", dram_req, 1);
      chk("stall_dram_addr", dram_addr, 21'h1F000);
      chk("stall_dram_rnw", dram_rnw, 0);
      chk("stall_dram_wdata", dram_wdata, 16'hA55A);
      chk("stall_cpu_next", cpu_next, 0);
    end
    ph_en = 1'b1;
    dcyc();
    drain("cpu_write");

    // Reset at c1 of a video cycle aborts it with no strobe.
    video_go = 1'b1; video_bw = 5'b00_011; video_addr = 21'h15555;
    push_grant(W_VID, video_addr, 1'b1, 16'h0000);
    dcyc();
    tick();
    res = 1'b1;
    tick();
    res = 1'b0; video_go = 1'b0;
    chk("mid_rst_dram_req", dram_req, 0);
    chk("mid_rst_next_video", next_video, 0);
    chk("mid_rst_dram_rnw", dram_rnw, 1);
    chk("mid_rst_dram_addr", dram_addr, 0);
    chk("mid_rst_dram_wdata", dram_wdata, 0);
    chk("mid_rst_pulses", {video_next, video_strobe, cpu_strobe}, 0);
    tick();
    tick();
    drain("mid_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
